hd_rr_arbiter: RTL and testbench

- N-way round-robin arbiter that merges N independent ready/valid source channels onto one shared downstream ready/valid channel.
- Sits in front of a single shared sink, such as one HD pipeline stage or a shared memory/bus port.
- Grants one source per transfer and registers the winning beat into an output stage.
- Sustains one beat per cycle when the sink is always ready.

---
 rtl/hd_arb_pkg.sv | 35 +++
 rtl/hd_rr_pick.sv | 29 ++
 rtl/hd_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_hd_rr_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hd_arb_pkg.sv
// Shared defaults and the rotate-priority pick function for the hd_rr_arbiter slice.
package hd_arb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_SRC    = 4;
    localparam int MAX_SRC        = 16;
    localparam int IDX_W          = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (n <= MAX_SRC).
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t r;
        int    j;
        r = '0;
        // Walk downwards so the lowest rotated offset is the last assignment made.
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (req[j[IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hd_rr_pick.sv
// Rotate-priority encoder: one-hot grant and index of the first requester at or after ptr.
// Latency: purely combinational.
// Backpressure: none; gnt_vld is low when no request is present.
module hd_rr_pick
    import hd_arb_pkg::*;
#(
    parameter int NUM_SRC  = DEF_NUM_SRC,
    parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                gnt_vld,
    output logic [NUM_SRC-1:0]  gnt_onehot,
    output logic [ID_WIDTH-1:0] gnt_idx
);

    pick_t pick;

    always_comb begin
        pick       = rr_pick(MAX_SRC'(req), IDX_W'(ptr), NUM_SRC);
        gnt_vld    = pick.found;
        gnt_idx    = pick.idx[ID_WIDTH-1:0];
        gnt_onehot = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pick.found && (pick.idx == IDX_W'(i))) gnt_onehot[i] = 1'b1;
        end
    end

endmodule

// File: rtl/hd_rr_arbiter.sv
// N-way round-robin merge onto one registered output stage; HD_ARB_LOCK_EN adds packet lock.
// Latency: one cycle from source transfer to dest_valid; one beat per cycle when dest_ready stays high.
// Backpressure: src_ready is gated by ~dest_valid | dest_ready, so a stalled sink stalls every source.
module hd_rr_arbiter
    import hd_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_SRC    = DEF_NUM_SRC,
    parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
`ifdef HD_ARB_LOCK_EN
    input  logic [NUM_SRC-1:0]            src_last,
`endif
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          dest_valid,
    output logic [DATA_WIDTH-1:0]         dest_data,
    output logic [ID_WIDTH-1:0]           dest_id,
`ifdef HD_ARB_LOCK_EN
    output logic                          dest_last,
`endif
    input  logic                          dest_ready
);

    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic                  dest_valid_q, dest_valid_d;
    logic [DATA_WIDTH-1:0] dest_data_q, dest_data_d;
    logic [ID_WIDTH-1:0]   dest_id_q, dest_id_d;
`ifdef HD_ARB_LOCK_EN
    logic                  locked_q, locked_d;
    logic                  dest_last_q, dest_last_d;
    logic                  win_last;
`endif

    logic [NUM_SRC-1:0]    pick_req;
    logic [ID_WIDTH-1:0]   pick_ptr;
    logic                  gnt_vld;
    logic [NUM_SRC-1:0]    gnt_onehot;
    logic [ID_WIDTH-1:0]   gnt_idx;
    logic                  load_en;
    logic                  src_xfer;
    logic [DATA_WIDTH-1:0] win_data;
    logic [ID_WIDTH-1:0]   nxt_ptr;

`ifdef HD_ARB_LOCK_EN
    // While a packet is open only its owner may win; dest_id_q still names that owner.
    assign pick_req = locked_q ? (src_valid & (NUM_SRC'(1) << dest_id_q)) : src_valid;
    assign pick_ptr = locked_q ? dest_id_q : ptr_q;
    assign win_last = |(src_last & gnt_onehot);
`else
    assign pick_req = src_valid;
    assign pick_ptr = ptr_q;
`endif

    hd_rr_pick #(
        .NUM_SRC  (NUM_SRC),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req        (pick_req),
        .ptr        (pick_ptr),
        .gnt_vld    (gnt_vld),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    assign load_en   = ~dest_valid_q | dest_ready;
    assign src_xfer  = load_en & gnt_vld;
    assign src_ready = gnt_onehot & {NUM_SRC{src_xfer}};
    assign nxt_ptr   = (gnt_idx == ID_WIDTH'(NUM_SRC - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_onehot[i]) win_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        dest_valid_d = dest_valid_q;
        dest_data_d  = dest_data_q;
        dest_id_d    = dest_id_q;
`ifdef HD_ARB_LOCK_EN
        locked_d     = locked_q;
        dest_last_d  = dest_last_q;
`endif
        if (src_xfer) begin
            dest_valid_d = 1'b1;
            dest_data_d  = win_data;
            dest_id_d    = gnt_idx;
`ifdef HD_ARB_LOCK_EN
            dest_last_d  = win_last;
            locked_d     = ~win_last;
            if (win_last) ptr_d = nxt_ptr;
`else
            ptr_d        = nxt_ptr;
`endif
        end else if (dest_ready) begin
            dest_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            dest_valid_q <= 1'b0;
            dest_data_q  <= '0;
            dest_id_q    <= '0;
`ifdef HD_ARB_LOCK_EN
            locked_q     <= 1'b0;
            dest_last_q  <= 1'b0;
`endif
        end else begin
            ptr_q        <= ptr_d;
            dest_valid_q <= dest_valid_d;
            dest_data_q  <= dest_data_d;
            dest_id_q    <= dest_id_d;
`ifdef HD_ARB_LOCK_EN
            locked_q     <= locked_d;
            dest_last_q  <= dest_last_d;
`endif
        end
    end

    assign dest_valid = dest_valid_q;
    assign dest_data  = dest_data_q;
    assign dest_id    = dest_id_q;
`ifdef HD_ARB_LOCK_EN
    assign dest_last  = dest_last_q;
`endif

endmodule

// File: tb/tb_hd_rr_arbiter.sv
// Randomized bench for hd_rr_arbiter with a queue-based reference model and a decoupled output monitor.
// Define HD_ARB_LOCK_EN to also exercise packet lock.
module tb_hd_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    src_valid;
    logic [N*DW-1:0] src_data;
    logic [N-1:0]    src_ready;
    logic            dest_valid;
    logic [DW-1:0]   dest_data;
    logic [IW-1:0]   dest_id;
    logic            dest_ready;
`ifdef HD_ARB_LOCK_EN
    logic [N-1:0]    src_last;
    logic            dest_last;
`endif

    hd_rr_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(N), .ID_WIDTH(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
`ifdef HD_ARB_LOCK_EN
        .src_last   (src_last),
`endif
        .src_ready  (src_ready),
        .dest_valid (dest_valid),
        .dest_data  (dest_data),
        .dest_id    (dest_id),
`ifdef HD_ARB_LOCK_EN
        .dest_last  (dest_last),
`endif
        .dest_ready (dest_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int id; logic [DW-1:0] data; logic last; } exp_t;

    beat_t        src_q [N][$];
    exp_t         exp_q [$];
    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           accepted [N];
    int           delivered [N];
    int           dropped [N];
    int           ptr_m = 0;
    bit           dv_m = 1'b0;
    bit           locked_m = 1'b0;
    int           lock_w = 0;
    int           valid_pct = 100;
    int           ready_pct = 100;
    logic [N-1:0] allow = '0;
    int           seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // last_every: 1 = every beat ends a packet, k = every k-th beat, 0 = random (batch always ends closed)
    task automatic add_beats(input int s, input int cnt, input int last_every);
        beat_t bt;
        for (int b = 0; b < cnt; b++) begin
            bt.data = {8'(s), 24'(seq)};
            seq++;
            if (last_every == 0) bt.last = ($urandom_range(2) == 0) || (b == cnt - 1);
            else                 bt.last = ((b + 1) % last_every) == 0;
            src_q[s].push_back(bt);
        end
    endtask

    function automatic bit pending();
        bit p = (exp_q.size() != 0);
        for (int s = 0; s < N; s++) if (src_q[s].size() != 0) p = 1'b1;
        return p;
    endfunction

    // A raised valid is held with its beat until it transfers.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!src_valid[i]) begin
                if (allow[i] && src_q[i].size() != 0 && $urandom_range(99) < valid_pct) begin
                    src_valid[i] = 1'b1;
                    src_data[i*DW +: DW] = src_q[i][0].data;
`ifdef HD_ARB_LOCK_EN
                    src_last[i] = src_q[i][0].last;
`endif
                end else begin
                    src_data[i*DW +: DW] = $urandom;
                end
            end
        end
        dest_ready = ($urandom_range(99) < ready_pct);
    endtask

    // Reference model: decide this cycle's grant from the arbitration rules, then advance one clock.
    task automatic cycle();
        int           w;
        bit           any, load, xfer, scan;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        beat_t        dummy;
        @(negedge clk);
        any = 1'b0; w = 0; scan = 1'b1;
`ifdef HD_ARB_LOCK_EN
        if (locked_m) begin
            any = src_valid[lock_w]; w = lock_w; scan = 1'b0;
        end
`endif
        if (scan) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr_m + k) % N;
                if (!any && src_valid[j]) begin any = 1'b1; w = j; end
            end
        end
        load    = !dv_m || dest_ready;
        xfer    = any && load;
        exp_rdy = xfer ? (N'(1) << w) : '0;
        chk("src_ready", src_ready, exp_rdy);
        if (xfer) begin
            e.id = w; e.data = src_q[w][0].data; e.last = src_q[w][0].last;
            exp_q.push_back(e);
            accepted[w]++;
            dv_m = 1'b1;
`ifdef HD_ARB_LOCK_EN
            if (e.last) begin locked_m = 1'b0; ptr_m = (w + 1) % N; end
            else        begin locked_m = 1'b1; lock_w = w; end
`else
            ptr_m = (w + 1) % N;
`endif
        end else if (dest_ready) begin
            dv_m = 1'b0;
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            dummy = src_q[w].pop_front();
            src_valid[w] = 1'b0;
        end
        drive();
    endtask

    // Output monitor: pops the scoreboard on every dest transfer and checks stall stability.
    initial begin : monitor
        bit            stall;
        logic [DW-1:0] hold_data;
        logic [IW-1:0] hold_id;
        exp_t          e;
        stall = 1'b0; hold_data = '0; hold_id = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_data", dest_data, hold_data);
                    chk("stall_id", dest_id, hold_id);
                end
                if (dest_valid && dest_ready) begin
                    chk("beat_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("dest_id", dest_id, e.id);
                        chk("dest_data", dest_data, e.data);
`ifdef HD_ARB_LOCK_EN
                        chk("dest_last", dest_last, e.last);
`endif
                        delivered[e.id]++;
                    end
                end
                stall = dest_valid && !dest_ready;
                hold_data = dest_data;
                hold_id = dest_id;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

    initial begin : stim
        src_valid = '0; src_data = '0; dest_ready = 1'b0;
`ifdef HD_ARB_LOCK_EN
        src_last = '0;
`endif
        #12;
        chk("reset_dest_valid", dest_valid, 0);
        chk("reset_dest_data", dest_data, 0);
        chk("reset_dest_id", dest_id, 0);
`ifdef HD_ARB_LOCK_EN
        chk("reset_dest_last", dest_last, 0);
`endif
        @(posedge clk); #1 rst = 1'b0;

        // All sources busy, sink always ready: strict rotation at one beat per cycle.
        for (int s = 0; s < N; s++) add_beats(s, 6, 1);
        allow = '1; valid_pct = 100; ready_pct = 100;
        drive();
        repeat (26) cycle();

        // Sink stalls five cycles with sources 1 and 2 waiting.
        add_beats(1, 1, 1); add_beats(2, 1, 1);
        allow = 4'b0110; ready_pct = 0;
        drive();
        repeat (4) cycle();
        ready_pct = 100;
        repeat (6) cycle();

        // Sparse traffic with idle gaps: source 3 then source 0.
        allow = 4'b1000; add_beats(3, 1, 1);
        repeat (5) cycle();
        allow = 4'b0001; add_beats(0, 1, 1);
        repeat (5) cycle();

        // Source 0 always requesting, source 2 requests once.
        add_beats(0, 10, 1); allow = 4'b0001;
        repeat (3) cycle();
        add_beats(2, 1, 1); allow = 4'b0101;
        repeat (12) cycle();

`ifdef HD_ARB_LOCK_EN
        // Source 1 owns a 3-beat packet while source 0 waits.
        add_beats(1, 3, 3); add_beats(0, 2, 1);
        allow = 4'b0010;
        drive();
        repeat (2) cycle();
        allow = 4'b0011;
        repeat (10) cycle();
`endif

        // Randomized traffic and backpressure.
        for (int s = 0; s < N; s++) add_beats(s, 40, 0);
        allow = '1; valid_pct = 50; ready_pct = 60;
        repeat (200) cycle();

        // Asynchronous reset while the output stage holds a beat.
        for (int t = 0; t < 50 && !dest_valid; t++) cycle();
        chk("pre_reset_valid", dest_valid, 1);
        #2 rst = 1'b1;
        #1 chk("async_reset_valid", dest_valid, 0);
        foreach (exp_q[k]) dropped[exp_q[k].id]++;
        exp_q.delete();
        dv_m = 1'b0; ptr_m = 0; locked_m = 1'b0;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < N; s++) add_beats(s, 4, 1);
        valid_pct = 100; ready_pct = 100;
        drive();
        #1 chk("first_grant_after_reset", src_ready, 4'b0001);
        repeat (60) cycle();

        // Drain everything still queued.
        allow = '1; valid_pct = 100; ready_pct = 100;
        for (int t = 0; t < 500 && pending(); t++) cycle();
        repeat (3) cycle();
        chk("scoreboard_empty", exp_q.size(), 0);
        for (int s = 0; s < N; s++) begin
            chk($sformatf("src%0d_queue_drained", s), src_q[s].size(), 0);
            chk($sformatf("src%0d_beats_accounted", s), delivered[s] + dropped[s], accepted[s]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
